// File: rtl/missing_duplicated_word_sched_pkg.sv
// Shared types for the missing_duplicated_word engine scheduler.
// Width-dependent typedefs live in the modules, which own W/N/R.
package missing_duplicated_word_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        RESP
    } state_t;

endpackage

// File: rtl/missing_duplicated_word_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo R.
module rr_arbiter #(
    parameter int R = 4
) (
    input  logic [R-1:0]         req,
    input  logic [$clog2(R)-1:0] ptr,
    output logic                 gnt_vld,
    output logic [$clog2(R)-1:0] gnt_id
);

    localparam int IW = $clog2(R);

    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int i = R - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % R);
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

endmodule

// File: rtl/missing_duplicated_word_sched.sv
// Time-shares one missing_duplicated_word engine between R requesters:
// round-robin grant, stream N words into the engine, start it, return the result.
module missing_duplicated_word_sched
    import missing_duplicated_word_sched_pkg::*;
#(
    parameter int W = 5,
    parameter int N = 17,
    parameter int R = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R-1:0]         req_vld,
    input  logic [R*W-1:0]       req_dat,
    output logic [R-1:0]         req_rdy,
    output logic                 rsp_vld_r,
    output logic [$clog2(R)-1:0] rsp_id_r,
    output logic [W-1:0]         rsp_dat_r,
    input  logic                 rsp_rdy,
    output logic                 eng_state_upt,
    output logic [$clog2(N)-1:0] eng_state_id,
    output logic [W-1:0]         eng_state_dat,
    output logic                 eng_cntrl_start,
    input  logic                 eng_cntrl_busy_r,
    input  logic [W-1:0]         eng_cntrl_dat_r
);

    localparam int IW = $clog2(R);
    localparam int NI = $clog2(N);

    typedef logic [W-1:0]  w_t;
    typedef logic [NI-1:0] id_t;
    typedef logic [IW-1:0] req_id_t;

    state_t  state_q, state_d;
    req_id_t gnt_id, rr_ptr, arb_id;
    id_t     wr_ptr;
    logic    arb_vld;
    logic    beat;
    logic    eng_done;
    w_t      cur_word;

    rr_arbiter #(.R(R)) u_arb (
        .req     (req_vld),
        .ptr     (rr_ptr),
        .gnt_vld (arb_vld),
        .gnt_id  (arb_id)
    );

    assign cur_word = req_dat[gnt_id*W +: W];
    assign beat     = (state_q == LOAD) && req_vld[gnt_id];
    assign eng_done = (state_q == RUN) && !eng_cntrl_busy_r;

    always_comb begin
        state_d         = state_q;
        req_rdy         = '0;
        eng_state_upt   = 1'b0;
        eng_state_id    = '0;
        eng_state_dat   = '0;
        eng_cntrl_start = 1'b0;
        unique case (state_q)
            IDLE: if (arb_vld) state_d = LOAD;
            LOAD: begin
                req_rdy[gnt_id] = 1'b1;
                if (beat) begin
                    eng_state_upt = 1'b1;
                    eng_state_id  = wr_ptr;
                    eng_state_dat = cur_word;
                    if (wr_ptr == id_t'(N - 1)) state_d = START;
                end
            end
            START: begin
                eng_cntrl_start = 1'b1;
                state_d         = RUN;
            end
            RUN:  if (!eng_cntrl_busy_r) state_d = RESP;
            RESP: if (rsp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr    <= '0;
            wr_ptr    <= '0;
            gnt_id    <= '0;
            rsp_vld_r <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (arb_vld) begin
                    gnt_id <= arb_id;
                    rr_ptr <= (arb_id == req_id_t'(R - 1)) ? '0 : arb_id + req_id_t'(1);
                    wr_ptr <= '0;
                end
                LOAD: if (beat) wr_ptr <= wr_ptr + id_t'(1);
                RUN:  if (!eng_cntrl_busy_r) rsp_vld_r <= 1'b1;
                RESP: if (rsp_rdy) rsp_vld_r <= 1'b0;
                default: ;
            endcase
        end
    end

    // Result payload is plain data: captured when the engine finishes, never reset.
    always_ff @(posedge clk) begin
        if (!rst && eng_done) begin
            rsp_dat_r <= eng_cntrl_dat_r;
            rsp_id_r  <= gnt_id;
        end
    end

endmodule

// File: tb/tb_missing_duplicated_word_sched.sv
// Bench for missing_duplicated_word_sched: a behavioural engine per DUT, requester
// drivers, and a response scoreboard fed with hand-derived expected results.
module tb_missing_duplicated_word_sched;

    localparam int SW = 5, SN = 5, SR = 3;
    localparam int BW = 5, BN = 17, BR = 4;

    typedef logic [SW-1:0] job_t [SN];
    typedef struct {int id; int dat;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, n_start = 0, cyc = 0, start_cyc = 0;
    logic vld_prev = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    // small instance (W=5, N=5, R=3)
    logic            tb_vld [SR];
    logic [SW-1:0]   tb_dat [SR];
    logic [SR-1:0]   req_vld, req_rdy;
    logic [SR*SW-1:0] req_dat;
    logic            rsp_vld_r, rsp_rdy;
    logic [1:0]      rsp_id_r;
    logic [SW-1:0]   rsp_dat_r;
    logic            eng_state_upt, eng_cntrl_start, eng_cntrl_busy_r;
    logic [2:0]      eng_state_id;
    logic [SW-1:0]   eng_state_dat, eng_cntrl_dat_r;

    assign req_vld = {tb_vld[2], tb_vld[1], tb_vld[0]};
    assign req_dat = {tb_dat[2], tb_dat[1], tb_dat[0]};

    missing_duplicated_word_sched #(.W(SW), .N(SN), .R(SR)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_dat(req_dat), .req_rdy(req_rdy),
        .rsp_vld_r(rsp_vld_r), .rsp_id_r(rsp_id_r), .rsp_dat_r(rsp_dat_r), .rsp_rdy(rsp_rdy),
        .eng_state_upt(eng_state_upt), .eng_state_id(eng_state_id),
        .eng_state_dat(eng_state_dat), .eng_cntrl_start(eng_cntrl_start),
        .eng_cntrl_busy_r(eng_cntrl_busy_r), .eng_cntrl_dat_r(eng_cntrl_dat_r)
    );

    // default-parameter instance (W=5, N=17, R=4)
    logic [BR-1:0]    b_req_vld, b_req_rdy;
    logic [BR*BW-1:0] b_req_dat;
    logic             b_rsp_vld_r, b_rsp_rdy;
    logic [1:0]       b_rsp_id_r;
    logic [BW-1:0]    b_rsp_dat_r;
    logic             b_upt, b_start, b_busy;
    logic [4:0]       b_wid;
    logic [BW-1:0]    b_wdat, b_edat;

    missing_duplicated_word_sched #(.W(BW), .N(BN), .R(BR)) dut_big (
        .clk(clk), .rst(rst), .req_vld(b_req_vld), .req_dat(b_req_dat), .req_rdy(b_req_rdy),
        .rsp_vld_r(b_rsp_vld_r), .rsp_id_r(b_rsp_id_r), .rsp_dat_r(b_rsp_dat_r),
        .rsp_rdy(b_rsp_rdy), .eng_state_upt(b_upt), .eng_state_id(b_wid),
        .eng_state_dat(b_wdat), .eng_cntrl_start(b_start),
        .eng_cntrl_busy_r(b_busy), .eng_cntrl_dat_r(b_edat)
    );

    // Behavioural engines: busy for N+1 cycles after start; result is the XOR fold,
    // shown inverted while busy so an early capture is visible.
    logic [SW-1:0] e_mem [SN];
    logic [SW-1:0] e_res;
    logic          e_busy;
    int            e_cnt;
    logic [BW-1:0] f_mem [BN];
    logic [BW-1:0] f_res;
    logic          f_busy;
    int            f_cnt;

    function automatic logic [SW-1:0] fold_s();
        logic [SW-1:0] x = '0;
        for (int i = 0; i < SN; i++) x ^= e_mem[i];
        return x;
    endfunction

    function automatic logic [BW-1:0] fold_b();
        logic [BW-1:0] x = '0;
        for (int i = 0; i < BN; i++) x ^= f_mem[i];
        return x;
    endfunction

    assign eng_cntrl_busy_r = e_busy;
    assign eng_cntrl_dat_r  = e_busy ? ~e_res : e_res;
    assign b_busy           = f_busy;
    assign b_edat           = f_busy ? ~f_res : f_res;

    always @(posedge clk) begin
        if (eng_state_upt) e_mem[eng_state_id] <= eng_state_dat;
        if (rst) begin
            e_busy <= 1'b0; e_cnt <= 0;
        end else if (eng_cntrl_start) begin
            e_busy <= 1'b1; e_cnt <= SN; e_res <= fold_s();
        end else if (e_busy) begin
            if (e_cnt == 0) e_busy <= 1'b0;
            else e_cnt <= e_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (b_upt) f_mem[b_wid] <= b_wdat;
        if (rst) begin
            f_busy <= 1'b0; f_cnt <= 0;
        end else if (b_start) begin
            f_busy <= 1'b1; f_cnt <= BN; f_res <= fold_b();
        end else if (f_busy) begin
            if (f_cnt == 0) f_busy <= 1'b0;
            else f_cnt <= f_cnt - 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard, start->response latency and write-enable legality.
    always @(negedge clk) begin
        if (eng_cntrl_start) begin
            start_cyc = cyc;
            n_start++;
        end
        if (eng_state_upt) check("upt_beat", 32'(|(req_rdy & req_vld)), 1);
        if (!rst && rsp_vld_r && !vld_prev) check("lat", 32'(cyc - start_cyc), SN + 3);
        vld_prev = rsp_vld_r;
        if (!rst && rsp_vld_r && rsp_rdy) begin
            if (exp_q.size() == 0) check("rsp_unexp", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id_r), mon_e.id);
                check("rsp_dat", 32'(rsp_dat_r), mon_e.dat);
            end
        end
    end

    task automatic send_job(input int r, input job_t w, input int stall_at, input int stall_len);
        int waited;
        for (int i = 0; i < SN; i++) begin
            tb_vld[r] = 1'b1;
            tb_dat[r] = w[i];
            waited = 0;
            forever begin
                @(negedge clk);
                if (req_rdy[r]) break;
                waited++;
                if (waited > 300) break;
            end
            if (waited > 300) begin
                check($sformatf("tmo_r%0d", r), 0, 1);
                tb_vld[r] = 1'b0;
                return;
            end
            check("wr_idx", 32'(eng_state_id), 32'(i));
            check("wr_dat", 32'(eng_state_dat), 32'(w[i]));
            @(posedge clk); #1;
            if (i == stall_at) begin
                tb_vld[r] = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    check("stall_upt", 32'(eng_state_upt), 0);
                    @(posedge clk); #1;
                end
            end
        end
        tb_vld[r] = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic push(input int id, input int dat);
        exp_t e;
        e.id = id; e.dat = dat;
        exp_q.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, n;
        logic [SW-1:0] snap_dat;
        logic [1:0]    snap_id;
        for (int r = 0; r < SR; r++) begin tb_vld[r] = 1'b1; tb_dat[r] = '0; end
        rsp_rdy = 1'b1;
        b_req_vld = '0; b_req_dat = '0; b_rsp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_vld", 32'(rsp_vld_r), 0);
        check("rst_req_rdy", 32'(req_rdy), 0);
        check("rst_upt", 32'(eng_state_upt), 0);
        check("rst_start", 32'(eng_cntrl_start), 0);
        check("rst_big_rdy", 32'(b_req_rdy), 0);
        @(posedge clk); #1;
        for (int r = 0; r < SR; r++) tb_vld[r] = 1'b0;
        rst = 1'b0;

        // single job from requester 1
        push(1, 9);
        s0 = n_start;
        send_job(1, '{5'd3, 5'd7, 5'd3, 5'd9, 5'd7}, -1, 0);
        wait_drain(50);
        check("start_once", 32'(n_start - s0), 1);

        // round-robin with everybody requesting
        do_reset();
        push(0, 2); push(1, 20); push(2, 12); push(0, 6);
        fork
            begin
                send_job(0, '{5'd5, 5'd5, 5'd2, 5'd8, 5'd8}, -1, 0);
                send_job(0, '{5'd31, 5'd3, 5'd31, 5'd3, 5'd6}, -1, 0);
            end
            send_job(1, '{5'd10, 5'd11, 5'd10, 5'd11, 5'd20}, -1, 0);
            send_job(2, '{5'd30, 5'd1, 5'd1, 5'd30, 5'd12}, -1, 0);
        join
        wait_drain(100);

        // stalled requester
        push(2, 4);
        send_job(2, '{5'd1, 5'd1, 5'd4, 5'd6, 5'd6}, 1, 4);
        wait_drain(50);

        // response backpressure with another requester waiting
        rsp_rdy = 1'b0;
        push(0, 13);
        send_job(0, '{5'd4, 5'd4, 5'd9, 5'd9, 5'd13}, -1, 0);
        fork
            begin
                push(1, 16);
                send_job(1, '{5'd14, 5'd15, 5'd14, 5'd15, 5'd16}, -1, 0);
            end
            begin
                n = 0;
                while (!rsp_vld_r && n < 100) begin @(negedge clk); n++; end
                check("bp_seen", 32'(rsp_vld_r), 1);
                snap_dat = rsp_dat_r;
                snap_id  = rsp_id_r;
                repeat (10) begin
                    @(negedge clk);
                    check("bp_vld", 32'(rsp_vld_r), 1);
                    check("bp_dat", 32'(rsp_dat_r), 32'(snap_dat));
                    check("bp_id", 32'(rsp_id_r), 32'(snap_id));
                    check("bp_rdy", 32'(req_rdy), 0);
                end
                @(posedge clk); #1 rsp_rdy = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("bp_idle", 32'(req_rdy), 0);
                @(negedge clk);
                check("bp_grant", 32'(req_rdy), 32'b010);
            end
        join
        wait_drain(50);

        // reset while the engine runs: job dropped, pointer back to requester 0
        send_job(1, '{5'd1, 5'd2, 5'd1, 5'd2, 5'd3}, -1, 0);
        n = 0;
        @(negedge clk);
        while (!eng_cntrl_start && n < 20) begin @(negedge clk); n++; end
        check("rr_start_seen", 32'(eng_cntrl_start), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstrun_vld", 32'(rsp_vld_r), 0);
        check("rstrun_rdy", 32'(req_rdy), 0);
        repeat (SN + 4) @(negedge clk);
        check("rstrun_norsp", 32'(rsp_vld_r), 0);
        push(0, 19); push(2, 25);
        fork
            send_job(0, '{5'd2, 5'd2, 5'd2, 5'd2, 5'd19}, -1, 0);
            send_job(2, '{5'd7, 5'd7, 5'd25, 5'd8, 5'd8}, -1, 0);
        join
        wait_drain(100);

        // default parameters: 0..7 twice then 31, from requester 3
        for (int i = 0; i < BN; i++) begin
            b_req_vld = 4'b1000;
            b_req_dat[15 +: 5] = (i < 16) ? 5'(i % 8) : 5'd31;
            n = 0;
            @(negedge clk);
            while (!b_req_rdy[3] && n < 100) begin @(negedge clk); n++; end
            if (!b_req_rdy[3]) begin check("big_tmo", 0, 1); break; end
            @(posedge clk); #1;
        end
        b_req_vld = '0;
        n = 0;
        @(negedge clk);
        while (!b_rsp_vld_r && n < 100) begin @(negedge clk); n++; end
        check("big_vld", 32'(b_rsp_vld_r), 1);
        check("big_id", 32'(b_rsp_id_r), 3);
        check("big_dat", 32'(b_rsp_dat_r), 31);
        repeat (2) @(negedge clk);
        check("big_done", 32'(b_rsp_vld_r), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
